fifo_sync_param: RTL and testbench

//   Parametrised single-clock FIFO for 32-bit packet buffering between pipeline stages.
//   - Configurable width and depth.
//   - First-word-fall-through (FWFT) read data.
//   - Simultaneous read and write.
//   - Almost-full / almost-empty flags, occupancy count, synchronous flush, sticky error flags.
//   - No tri-state outputs.

---
 rtl/fifo_sync_param.sv | 103 ++++++++++
 tb/tb_fifo_sync_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with first-word-fall-through read data, occupancy flags,
// a synchronous flush and sticky overflow/underflow indicators.
module fifo_sync_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic empty_s, full_s, rd_ok, wr_ok, flush;

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == CW'(DEPTH));
  assign flush   = reset | clear;

  // A read frees a slot in the same edge, so a full FIFO can still take a write alongside it.
  assign rd_ok = rd & ~empty_s;
  assign wr_ok = wr & (~full_s | rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr && !wr_ok) begin
        overflow_d = 1'b1;
      end
      if (rd && !rd_ok) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    count_q     <= count_d;
    overflow_q  <= overflow_d;
    underflow_q <= underflow_d;
  end

  // Storage is never reset; flushing only rewinds the pointers.
  always_ff @(posedge clock) begin
    if (!flush && wr_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = empty_s ? '0 : mem_q[rd_ptr_q];
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: directed sequences plus a short random run, with a
// queue scoreboard popped by a monitor whenever the FIFO presents a word that is being read.
module tb_fifo_sync_param;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        wr    = 1'b0;
  logic        rd    = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];
  int          m_cnt = 0;
  bit          m_ovf = 0;
  bit          m_unf = 0;

  fifo_sync_param dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .wr           (wr),
    .data_in      (data_in),
    .rd           (rd),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs are stable at the falling edge, so a pending accepted read is known here.
  always @(negedge clock) begin
    if (reset === 1'b0 && clear === 1'b0 && rd === 1'b1 && empty === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_pop: DUT presents %h for a read, expected no word queued", data_out);
      end else begin
        chk("sb_data_out", data_out, exp_q.pop_front());
      end
    end
  end

  task automatic check_state();
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == DEPTH));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("almost_full", 32'(almost_full), 32'(m_cnt >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 2));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    if (m_cnt == 0) chk("data_out_empty", data_out, 32'h0);
  endtask

  // One clock: drive inputs, let the edge pass, update the model, compare state.
  task automatic step(input bit w, input logic [31:0] d, input bit r,
                      input bit clr = 1'b0, input bit rst = 1'b0);
    bit rok, wok;
    wr = w; data_in = d; rd = r; clear = clr; reset = rst;
    rok = r && (m_cnt != 0);
    wok = w && ((m_cnt != DEPTH) || rok);
    @(posedge clock);
    #1;
    if (rst || clr) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
      exp_q.delete();
    end else begin
      if (wok) exp_q.push_back(d);
      m_cnt += int'(wok) - int'(rok);
      if (w && !wok) m_ovf = 1;
      if (r && !rok) m_unf = 1;
    end
    check_state();
  endtask

  logic [31:0] t3_order [8] = '{32'hA4, 32'hA5, 32'hA6, 32'hA7, 32'hB0, 32'hB1, 32'hB2, 32'hB3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clock); #1;
    step(0, 0, 0, 0, 1);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_almost_empty", 32'(almost_empty), 32'h1);
    chk("rst_count", 32'(count), 32'h0);

    // Fill, then overflow.
    for (int i = 0; i < 8; i++) begin
      step(1, 32'hA0 + 32'(i), 0);
      if (i == 4) chk("t1_af_at5", 32'(almost_full), 32'h0);
      if (i == 5) chk("t1_af_at6", 32'(almost_full), 32'h1);
    end
    chk("t1_full", 32'(full), 32'h1);
    chk("t1_count", 32'(count), 32'h8);
    step(1, 32'hEE, 0);
    chk("t1_overflow", 32'(overflow), 32'h1);
    chk("t1_head_kept", data_out, 32'hA0);

    // Drain in order, then underflow.
    for (int i = 0; i < 8; i++) begin
      chk("t2_head", data_out, 32'hA0 + 32'(i));
      step(0, 0, 1);
    end
    chk("t2_empty", 32'(empty), 32'h1);
    step(0, 0, 1);
    chk("t2_underflow", 32'(underflow), 32'h1);

    // Full with simultaneous rd+wr, then drain across the pointer wrap.
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 32'hA0 + 32'(i), 0);
    for (int i = 0; i < 4; i++) step(1, 32'hB0 + 32'(i), 1);
    chk("t3_count", 32'(count), 32'h8);
    chk("t3_no_overflow", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain", data_out, t3_order[i]);
      step(0, 0, 1);
    end

    // rd+wr on empty: read rejected, write taken.
    step(1, 32'h55, 1);
    chk("t4_underflow", 32'(underflow), 32'h1);
    chk("t4_count", 32'(count), 32'h1);
    chk("t4_data", data_out, 32'h55);

    // Clear, then reset, each with a concurrent write at count 5.
    for (int pass = 0; pass < 2; pass++) begin
      step(0, 0, 0, 1);
      step(0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 32'hC0 + 32'(i), 0);
      chk("t5_count5", 32'(count), 32'h5);
      step(1, 32'hFF, 1, (pass == 0), (pass == 1));
      chk("t5_count0", 32'(count), 32'h0);
      chk("t5_empty", 32'(empty), 32'h1);
      chk("t5_underflow_clr", 32'(underflow), 32'h0);
      step(0, 0, 0);
      chk("t5_discard", data_out, 32'h0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 2 * DEPTH && m_cnt != 0; i++) step(0, 0, 1);
    chk("final_sb_empty", 32'(exp_q.size()), 32'h0);

    wr = 0; rd = 0; clear = 0; reset = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
